// File: rtl/rf_pkg.sv
// Shared register-file definitions: geometry, arbiter defaults and the write-beat record.
package rf_pkg;

   localparam int RF_AW       = 5;
   localparam int RF_DW       = 32;
   localparam int RF_DEPTH    = 32;
   localparam int RF_NREQ     = 4;
   localparam int RF_MAX_WAIT = 8;

   typedef struct packed {
      logic [RF_AW-1:0] addr;
      logic [RF_DW-1:0] data;
   } rf_wr_t;

   // Wait counters must be able to hold MAX_WAIT itself.
   function automatic int cntWidth(input int maxWait);
      return $clog2(maxWait + 1);
   endfunction

endpackage

// File: rtl/rf_write_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester at or after i_ptr, wrapping N-1 -> 0.
module rr_pick #(
   parameter  int N  = 4,
   localparam int PW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  i_req,
   input  logic [PW-1:0] i_ptr,
   output logic [N-1:0]  o_grant,
   output logic [PW-1:0] o_idx,
   output logic          o_any
);

   int w_j;

   always_comb begin
      o_grant = '0;
      o_idx   = '0;
      o_any   = 1'b0;
      w_j     = 0;
      for (int k = 0; k < N; k++) begin
         w_j = (int'(i_ptr) + k) % N;
         if (!o_any && i_req[w_j]) begin
            o_any        = 1'b1;
            o_grant[w_j] = 1'b1;
            o_idx        = PW'(w_j);
         end
      end
   end

endmodule

// File: rtl/rf_write_arbiter.sv
// Shares the register-file write port among NREQ writeback requesters:
// round-robin with a starvation override, winner registered onto the write port.
module rf_write_arbiter
   import rf_pkg::*;
#(
   parameter int NREQ     = RF_NREQ,
   parameter int AW       = RF_AW,
   parameter int DW       = RF_DW,
   parameter int MAX_WAIT = RF_MAX_WAIT
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NREQ-1:0]      i_req_valid,
   input  logic [NREQ*AW-1:0]   i_req_addr,
   input  logic [NREQ*DW-1:0]   i_req_data,
   output logic [NREQ-1:0]      o_req_ready,
   output logic                 o_rf_write,
   output logic [AW-1:0]        o_rf_wreg,
   output logic [DW-1:0]        o_rf_wdata,
   output logic [NREQ-1:0]      o_starved
);

   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int CW = cntWidth(MAX_WAIT);
   localparam logic [CW-1:0] MAXC    = CW'(MAX_WAIT);
   localparam logic [PW-1:0] LASTIDX = PW'(NREQ - 1);

   logic [PW-1:0]   r_ptr;
   logic [CW-1:0]   r_cnt [NREQ];
   logic [NREQ-1:0] r_starved;
   logic            r_write;
   logic [AW-1:0]   r_wreg;
   logic [DW-1:0]   r_wdata;

   logic [NREQ-1:0] w_rrGrant;
   logic [PW-1:0]   w_rrIdx;
   logic            w_rrAny;
   logic [NREQ-1:0] w_grant;
   logic [PW-1:0]   w_idx;
   logic            w_starvHit;
   logic [CW-1:0]   w_cntNext [NREQ];
   logic [AW-1:0]   w_winAddr;
   logic [DW-1:0]   w_winData;

   rr_pick #(.N(NREQ)) u_pick (
      .i_req   (i_req_valid),
      .i_ptr   (r_ptr),
      .o_grant (w_rrGrant),
      .o_idx   (w_rrIdx),
      .o_any   (w_rrAny)
   );

   // A starved requester is itself valid, so the round-robin "any" flag still covers it.
   always_comb begin
      w_grant    = w_rrGrant;
      w_idx      = w_rrIdx;
      w_starvHit = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         if (!w_starvHit && i_req_valid[i] && r_starved[i]) begin
            w_starvHit = 1'b1;
            w_grant    = '0;
            w_grant[i] = 1'b1;
            w_idx      = PW'(i);
         end
      end
   end

   assign w_winAddr = i_req_addr[w_idx*AW +: AW];
   assign w_winData = i_req_data[w_idx*DW +: DW];

   always_comb begin
      for (int i = 0; i < NREQ; i++) begin
         w_cntNext[i] = '0;
         if (i_req_valid[i] && !w_grant[i]) begin
            w_cntNext[i] = (r_cnt[i] == MAXC) ? MAXC : r_cnt[i] + CW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ptr     <= '0;
         r_starved <= '0;
         r_write   <= 1'b0;
         r_wreg    <= '0;
         r_wdata   <= '0;
         for (int i = 0; i < NREQ; i++) begin
            r_cnt[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NREQ; i++) begin
            r_cnt[i]     <= w_cntNext[i];
            r_starved[i] <= (w_cntNext[i] == MAXC);
         end
         r_write <= w_rrAny;
         if (w_rrAny) begin
            r_wreg  <= w_winAddr;
            r_wdata <= w_winData;
            r_ptr   <= (w_idx == LASTIDX) ? '0 : w_idx + PW'(1);
         end
      end
   end

   // Grants are suppressed during reset so nobody believes a write was accepted.
   assign o_req_ready = rst_n ? w_grant : '0;
   assign o_rf_write  = r_write;
   assign o_rf_wreg   = r_wreg;
   assign o_rf_wdata  = r_wdata;
   assign o_starved   = r_starved;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed self-checking bench for rf_write_arbiter (NREQ=4, AW=5, DW=32, MAX_WAIT=8).
module tb_rf_write_arbiter;
   import rf_pkg::*;

   logic         clk = 1'b0;
   logic         rst_n = 1'b1;
   logic [3:0]   reqValid = '0;
   logic [19:0]  reqAddr = '0;
   logic [127:0] reqData = '0;
   logic [3:0]   reqReady;
   logic         rfWrite;
   logic [4:0]   rfWreg;
   logic [31:0]  rfWdata;
   logic [3:0]   starved;

   rf_wr_t reqTab [4];
   int total = 0;
   int bad   = 0;

   rf_write_arbiter #(.NREQ(4), .AW(5), .DW(32), .MAX_WAIT(8)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_req_valid (reqValid),
      .i_req_addr  (reqAddr),
      .i_req_data  (reqData),
      .o_req_ready (reqReady),
      .o_rf_write  (rfWrite),
      .o_rf_wreg   (rfWreg),
      .o_rf_wdata  (rfWdata),
      .o_starved   (starved)
   );

   // Free-running 10-time-unit clock.
   always #5 clk = ~clk;

   // Pack the requester table and valid mask onto the DUT inputs.
   task automatic applyStimulus(input logic [3:0] v);
      reqValid = v;
      for (int i = 0; i < 4; i++) begin
         reqAddr[i*5 +: 5]   = reqTab[i].addr;
         reqData[i*32 +: 32] = reqTab[i].data;
      end
   endtask

   // One comparison: count it, and report any disagreement.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      total++;
      assert (observed === expected)
      else begin
         bad++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic doReset();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
   endtask

   // Directed sequence; expected values are worked out by hand from the arbitration rules.
   initial begin
      for (int i = 0; i < 4; i++) reqTab[i] = '0;
      #1;
      rst_n = 1'b0;
      tick();
      reqTab[0] = '{addr: 5'd9, data: 32'd99};
      applyStimulus(4'b0001);
      #1;
      checkOutput("rst_ready", 32'(reqReady), 32'h0);
      checkOutput("rst_write", 32'(rfWrite), 32'h0);
      checkOutput("rst_wreg", 32'(rfWreg), 32'h0);
      checkOutput("rst_wdata", rfWdata, 32'h0);
      checkOutput("rst_starved", 32'(starved), 32'h0);
      applyStimulus(4'b0000);
      tick();
      rst_n = 1'b1;

      // Idle after release: nothing may be written.
      for (int k = 0; k < 5; k++) begin
         tick();
         checkOutput("idle_write", 32'(rfWrite), 32'h0);
         checkOutput("idle_wreg", 32'(rfWreg), 32'h0);
         checkOutput("idle_wdata", rfWdata, 32'h0);
         checkOutput("idle_ready", 32'(reqReady), 32'h0);
      end

      // Single requester: same-cycle grant, one-cycle write latency, held address when idle.
      reqTab[0] = '{addr: 5'd15, data: 32'd120};
      applyStimulus(4'b0001);
      #1;
      checkOutput("single_ready", 32'(reqReady), 32'h1);
      tick();
      checkOutput("single_write", 32'(rfWrite), 32'h1);
      checkOutput("single_wreg", 32'(rfWreg), 32'd15);
      checkOutput("single_wdata", rfWdata, 32'd120);
      applyStimulus(4'b0000);
      tick();
      checkOutput("after_write", 32'(rfWrite), 32'h0);
      checkOutput("after_wreg", 32'(rfWreg), 32'd15);
      checkOutput("after_wdata", rfWdata, 32'd120);

      // All four valid from pointer 0: grants rotate 0,1,2,3,0.
      doReset();
      for (int i = 0; i < 4; i++) reqTab[i] = '{addr: 5'(10 + i), data: 32'(100 + i)};
      applyStimulus(4'b1111);
      for (int k = 0; k < 5; k++) begin
         #1;
         checkOutput("rr_ready", 32'(reqReady), 32'(4'b0001 << (k % 4)));
         tick();
         checkOutput("rr_write", 32'(rfWrite), 32'h1);
         checkOutput("rr_wreg", 32'(rfWreg), 32'(10 + (k % 4)));
      end
      applyStimulus(4'b0000);

      // Starvation: pointer pinned alternately to 0/1 so req3 is passed over eight times.
      doReset();
      reqTab[0] = '{addr: 5'd1, data: 32'd11};
      reqTab[1] = '{addr: 5'd2, data: 32'd22};
      reqTab[3] = '{addr: 5'd3, data: 32'd33};
      applyStimulus(4'b1011);
      for (int k = 0; k < 8; k++) begin
         if (k % 2 == 0) force dut.r_ptr = 2'd0;
         else            force dut.r_ptr = 2'd1;
         #1;
         checkOutput("held_ready", 32'(reqReady), (k % 2 == 0) ? 32'h1 : 32'h2);
         checkOutput("held_starved", 32'(starved), 32'h0);
         tick();
      end
      release dut.r_ptr;
      #1;
      checkOutput("starved_flag", 32'(starved), 32'h8);
      checkOutput("starved_ready", 32'(reqReady), 32'h8);
      tick();
      checkOutput("starved_wreg", 32'(rfWreg), 32'd3);
      checkOutput("starved_wdata", rfWdata, 32'd33);
      checkOutput("starved_clear", 32'(starved), 32'h0);
      applyStimulus(4'b0011);
      #1;
      checkOutput("ptr_after_starve", 32'(reqReady), 32'h1);
      tick();
      applyStimulus(4'b0000);
      tick();

      // Same address from req1 and req2 with pointer at 1: writes land in grant order.
      reqTab[1] = '{addr: 5'd7, data: 32'd3};
      reqTab[2] = '{addr: 5'd7, data: 32'd9};
      applyStimulus(4'b0110);
      #1;
      checkOutput("same_ready1", 32'(reqReady), 32'h2);
      tick();
      checkOutput("same_wreg1", 32'(rfWreg), 32'd7);
      checkOutput("same_wdata1", rfWdata, 32'd3);
      applyStimulus(4'b0100);
      #1;
      checkOutput("same_ready2", 32'(reqReady), 32'h4);
      tick();
      checkOutput("same_write2", 32'(rfWrite), 32'h1);
      checkOutput("same_wdata2", rfWdata, 32'd9);
      applyStimulus(4'b0000);

      // Reset landing right after a grant to register 20 clears the port and the pointer.
      reqTab[2] = '{addr: 5'd20, data: 32'd132};
      applyStimulus(4'b0100);
      #1;
      checkOutput("pre_rst_ready", 32'(reqReady), 32'h4);
      tick();
      checkOutput("pre_rst_wreg", 32'(rfWreg), 32'd20);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("midrst_write", 32'(rfWrite), 32'h0);
      checkOutput("midrst_wreg", 32'(rfWreg), 32'h0);
      checkOutput("midrst_wdata", rfWdata, 32'h0);
      checkOutput("midrst_ready", 32'(reqReady), 32'h0);
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) reqTab[i] = '{addr: 5'(24 + i), data: 32'(200 + i)};
      applyStimulus(4'b1111);
      #1;
      checkOutput("post_rst_ptr", 32'(reqReady), 32'h1);
      tick();
      checkOutput("post_rst_wreg", 32'(rfWreg), 32'd24);
      applyStimulus(4'b0000);
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
